// File: rtl/game_pkg.sv
// Shared pixel and frame-control types for the game video path.
// Used by the layer compositor and its priority encoder.
package game_pkg;

  localparam int PIX_W = 16;
  localparam logic [PIX_W-1:0] KEY_COLOR = 16'hF81F;

  typedef logic [PIX_W-1:0] rgb565_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } frame_state_t;

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit encoder: reports whether any bit is set and the index of the lowest one.
// Index 0 is the highest priority, so the lowest set bit is the winner.
module prio_enc #(
  parameter  int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_vec,
  output logic         o_valid,
  output logic [W-1:0] o_idx
);

  // Scan downward so the final assignment comes from the lowest set bit.
  always_comb begin
    o_valid = |i_vec;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = W'(i);
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage sprite layer compositor with per-frame collision tracking.
// Picks the highest-priority opaque layer over the background and publishes overlaps once per frame.
module layer_compositor
  import game_pkg::*;
#(
  parameter  int                NUM_LAYERS = 8,
  parameter  logic [PIX_W-1:0]  KEY        = KEY_COLOR,
  localparam int                IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        frame_clk,
  input  logic                        pix_valid,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [NUM_LAYERS-1:0]       layer_hit,
  input  logic [NUM_LAYERS*PIX_W-1:0] layer_rgb,
  input  logic [PIX_W-1:0]            bg_rgb,
  input  logic [NUM_LAYERS-1:0]       collide_mask,
  output logic [PIX_W-1:0]            out_rgb,
  output logic                        out_valid,
  output logic [IDX_W-1:0]            out_layer,
  output logic                        out_is_bg,
  output logic [NUM_LAYERS-1:0]       frame_collide,
  output logic [IDX_W-1:0]            first_layer,
  output logic                        collide_irq
);

  localparam int CNT_W = $clog2(NUM_LAYERS + 1);

  if (NUM_LAYERS < 2) begin : g_bad_layers
    $error("layer_compositor: NUM_LAYERS must be at least 2");
  end

  logic [NUM_LAYERS-1:0] w_opaque;
  logic [NUM_LAYERS-1:0] w_part;
  logic                  w_win;
  logic [IDX_W-1:0]      w_win_idx;
  rgb565_t               w_sel_rgb;
  logic [CNT_W-1:0]      w_cnt;
  logic                  w_ov;

  logic                  r1_valid;
  logic                  r1_win;
  logic [IDX_W-1:0]      r1_idx;
  rgb565_t               r1_sel_rgb;
  rgb565_t               r1_bg;
  logic [NUM_LAYERS-1:0] r1_part;
  logic                  r1_ov;

  rgb565_t               r2_rgb;
  logic                  r2_valid;
  logic [IDX_W-1:0]      r2_layer;
  logic                  r2_is_bg;

  always_comb begin
    w_opaque = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_opaque[i] = pix_valid & layer_en[i] & layer_hit[i] &
                    (layer_rgb[i*PIX_W +: PIX_W] != KEY);
    end
  end

  assign w_part = w_opaque & collide_mask;

  prio_enc #(.N(NUM_LAYERS)) u_pix_enc (
    .i_vec   (w_opaque),
    .o_valid (w_win),
    .o_idx   (w_win_idx)
  );

  always_comb begin
    w_sel_rgb = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (w_win_idx == IDX_W'(i)) w_sel_rgb = layer_rgb[i*PIX_W +: PIX_W];
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_cnt = w_cnt + CNT_W'(w_part[i]);
    end
  end

  assign w_ov = (w_cnt >= CNT_W'(2));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r1_valid   <= 1'b0;
      r1_win     <= 1'b0;
      r1_idx     <= '0;
      r1_sel_rgb <= '0;
      r1_bg      <= '0;
      r1_part    <= '0;
      r1_ov      <= 1'b0;
    end else begin
      r1_valid   <= pix_valid;
      r1_win     <= w_win;
      r1_idx     <= w_win_idx;
      r1_sel_rgb <= w_sel_rgb;
      r1_bg      <= bg_rgb;
      r1_part    <= w_part;
      r1_ov      <= w_ov;
    end
  end

  // Invalid pixels blank to zero; they never have a winner, so they also read as background.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r2_rgb   <= '0;
      r2_valid <= 1'b0;
      r2_layer <= '0;
      r2_is_bg <= 1'b1;
    end else begin
      r2_valid <= r1_valid;
      r2_is_bg <= ~r1_win;
      r2_layer <= r1_win ? r1_idx : '0;
      if (!r1_valid)   r2_rgb <= '0;
      else if (r1_win) r2_rgb <= r1_sel_rgb;
      else             r2_rgb <= r1_bg;
    end
  end

  assign out_rgb   = r2_rgb;
  assign out_valid = r2_valid;
  assign out_layer = r2_layer;
  assign out_is_bg = r2_is_bg;

  frame_state_t          r_state;
  frame_state_t          w_next_state;
  logic                  r_frame_d;
  logic                  w_edge;
  logic                  w_publish;
  logic [NUM_LAYERS-1:0] r_acc;
  logic                  r_first_seen;
  logic [IDX_W-1:0]      r_first_idx;
  logic [IDX_W-1:0]      w_part_idx;
  logic                  w_part_any;
  logic [NUM_LAYERS-1:0] r_frame_collide;
  logic [IDX_W-1:0]      r_first_layer;
  logic                  r_irq;

  assign w_edge = frame_clk & ~r_frame_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_frame_d <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_frame_d <= frame_clk;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_edge) w_next_state = RUN;
      RUN:     w_next_state = RUN;
      default: w_next_state = IDLE;
    endcase
  end

  // The first edge after reset only starts a frame; there is nothing complete to publish yet.
  always_comb begin
    w_publish = 1'b0;
    case (r_state)
      RUN:     w_publish = w_edge;
      default: w_publish = 1'b0;
    endcase
  end

  prio_enc #(.N(NUM_LAYERS)) u_first_enc (
    .i_vec   (r1_part),
    .o_valid (w_part_any),
    .o_idx   (w_part_idx)
  );

  // On a frame edge the old frame is cleared first, so an overlap in that cycle opens the new frame.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_acc        <= '0;
      r_first_seen <= 1'b0;
      r_first_idx  <= '0;
    end else if (w_edge) begin
      r_acc        <= r1_ov ? r1_part : '0;
      r_first_seen <= r1_ov & w_part_any;
      r_first_idx  <= r1_ov ? w_part_idx : '0;
    end else if (r1_ov) begin
      r_acc <= r_acc | r1_part;
      if (!r_first_seen) begin
        r_first_seen <= 1'b1;
        r_first_idx  <= w_part_idx;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_frame_collide <= '0;
      r_first_layer   <= '0;
      r_irq           <= 1'b0;
    end else begin
      r_irq <= w_publish & (|r_acc);
      if (w_publish) begin
        r_frame_collide <= r_acc;
        r_first_layer   <= r_first_seen ? r_first_idx : '0;
      end
    end
  end

  assign frame_collide = r_frame_collide;
  assign first_layer   = r_first_layer;
  assign collide_irq   = r_irq;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: pixel priority, transparency, and per-frame collision publishing.
// Inputs change 1ns after the rising edge and outputs are sampled at that same point.
module tb_layer_compositor;

  localparam int NL = 8;
  localparam int PW = 16;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           frame_clk;
  logic           pix_valid;
  logic [NL-1:0]  layer_en;
  logic [NL-1:0]  layer_hit;
  logic [NL*PW-1:0] layer_rgb;
  logic [PW-1:0]  bg_rgb;
  logic [NL-1:0]  collide_mask;
  logic [PW-1:0]  out_rgb;
  logic           out_valid;
  logic [2:0]     out_layer;
  logic           out_is_bg;
  logic [NL-1:0]  frame_collide;
  logic [2:0]     first_layer;
  logic           collide_irq;

  int compareCount  = 0;
  int mismatchCount = 0;

  layer_compositor #(.NUM_LAYERS(NL)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .pix_valid     (pix_valid),
    .layer_en      (layer_en),
    .layer_hit     (layer_hit),
    .layer_rgb     (layer_rgb),
    .bg_rgb        (bg_rgb),
    .collide_mask  (collide_mask),
    .out_rgb       (out_rgb),
    .out_valid     (out_valid),
    .out_layer     (out_layer),
    .out_is_bg     (out_is_bg),
    .frame_collide (frame_collide),
    .first_layer   (first_layer),
    .collide_irq   (collide_irq)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic setRgb(input int idx, input logic [PW-1:0] val);
    layer_rgb[idx*PW +: PW] = val;
  endtask

  task automatic defaultColours();
    for (int i = 0; i < NL; i++) setRgb(i, PW'((i + 1) * 16'h1111));
  endtask

  task automatic idlePixel();
    pix_valid = 1'b0;
    layer_hit = '0;
  endtask

  // Drive one pixel for one cycle, then idle; after the second edge it sits in the output stage.
  task automatic applyStimulus(input logic valid, input logic [NL-1:0] en, input logic [NL-1:0] hit);
    pix_valid = valid;
    layer_en  = en;
    layer_hit = hit;
    tick();
    idlePixel();
    tick();
  endtask

  task automatic frameEdge();
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
  endtask

  task automatic overlapPixels(input logic [NL-1:0] hit, input int n);
    for (int k = 0; k < n; k++) begin
      pix_valid = 1'b1;
      layer_hit = hit;
      tick();
    end
    idlePixel();
    tick();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_rgb"},     32'(out_rgb),       32'h0);
    checkOutput({tag, "_valid"},   32'(out_valid),     32'h0);
    checkOutput({tag, "_layer"},   32'(out_layer),     32'h0);
    checkOutput({tag, "_isbg"},    32'(out_is_bg),     32'h1);
    checkOutput({tag, "_collide"}, 32'(frame_collide), 32'h0);
    checkOutput({tag, "_first"},   32'(first_layer),   32'h0);
    checkOutput({tag, "_irq"},     32'(collide_irq),   32'h0);
  endtask

  initial begin
    Reset        = 1'b1;
    frame_clk    = 1'b0;
    pix_valid    = 1'b0;
    layer_en     = '1;
    layer_hit    = '0;
    bg_rgb       = 16'h1234;
    collide_mask = '0;
    layer_rgb    = '0;
    defaultColours();
    tick();
    tick();
    checkReset("rst0");
    Reset = 1'b0;
    tick();

    frameEdge();
    checkOutput("first_edge_irq", 32'(collide_irq), 32'h0);
    tick();

    applyStimulus(1'b1, 8'hFF, 8'h24);
    checkOutput("prio_rgb",   32'(out_rgb),   32'h3333);
    checkOutput("prio_layer", 32'(out_layer), 32'd2);
    checkOutput("prio_isbg",  32'(out_is_bg), 32'h0);
    checkOutput("prio_valid", 32'(out_valid), 32'h1);

    setRgb(0, 16'hF81F);
    setRgb(3, 16'h07E0);
    applyStimulus(1'b1, 8'hFF, 8'h09);
    checkOutput("key_rgb",   32'(out_rgb),   32'h07E0);
    checkOutput("key_layer", 32'(out_layer), 32'd3);
    applyStimulus(1'b1, 8'hF7, 8'h09);
    checkOutput("en_rgb",   32'(out_rgb),   32'h1234);
    checkOutput("en_isbg",  32'(out_is_bg), 32'h1);
    checkOutput("en_layer", 32'(out_layer), 32'd0);
    applyStimulus(1'b0, 8'hFF, 8'h24);
    checkOutput("inv_rgb",   32'(out_rgb),   32'h0);
    checkOutput("inv_valid", 32'(out_valid), 32'h0);
    checkOutput("inv_isbg",  32'(out_is_bg), 32'h1);
    defaultColours();
    layer_en = '1;

    collide_mask = 8'h07;
    overlapPixels(8'h06, 4);
    frameEdge();
    checkOutput("coll_mask",  32'(frame_collide), 32'h06);
    checkOutput("coll_first", 32'(first_layer),   32'd1);
    checkOutput("coll_irq",   32'(collide_irq),   32'h1);
    tick();
    checkOutput("coll_irq_drop", 32'(collide_irq),   32'h0);
    checkOutput("coll_hold",     32'(frame_collide), 32'h06);
    frameEdge();
    checkOutput("quiet_mask", 32'(frame_collide), 32'h0);
    checkOutput("quiet_irq",  32'(collide_irq),   32'h0);

    collide_mask = 8'h01;
    overlapPixels(8'h11, 2);
    frameEdge();
    checkOutput("mask01_single", 32'(frame_collide), 32'h0);
    overlapPixels(8'h13, 1);
    frameEdge();
    checkOutput("mask01_triple", 32'(frame_collide), 32'h0);
    collide_mask = 8'h03;
    overlapPixels(8'h13, 1);
    frameEdge();
    checkOutput("mask03_triple", 32'(frame_collide), 32'h03);
    checkOutput("mask03_first",  32'(first_layer),   32'd0);

    pix_valid = 1'b1;
    layer_hit = 8'h03;
    tick();
    idlePixel();
    frameEdge();
    checkOutput("bound_n_mask", 32'(frame_collide), 32'h0);
    checkOutput("bound_n_irq",  32'(collide_irq),   32'h0);
    tick();
    frameEdge();
    checkOutput("bound_n1_mask", 32'(frame_collide), 32'h03);
    checkOutput("bound_n1_irq",  32'(collide_irq),   32'h1);

    collide_mask = 8'h07;
    pix_valid = 1'b1;
    layer_hit = 8'h06;
    tick();
    tick();
    Reset = 1'b1;
    #1;
    checkReset("rst_mid");
    tick();
    Reset = 1'b0;
    idlePixel();
    tick();
    frameEdge();
    checkOutput("rst_edge_irq",  32'(collide_irq),   32'h0);
    checkOutput("rst_edge_mask", 32'(frame_collide), 32'h0);
    overlapPixels(8'h06, 2);
    frameEdge();
    checkOutput("rst_next_mask",  32'(frame_collide), 32'h06);
    checkOutput("rst_next_first", 32'(first_layer),   32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
